pmod_xbar_axil: RTL and testbench
=================================

// Module: pmod_xbar_axil
// PURPOSE
// - Parametrised Pmod-to-peripheral crossbar with a working AXI4-Lite control port.
// - Routes PIN_W-bit peripheral channels to Pmod ports via per-Pmod select registers.
// - Blanks the output drivers of a Pmod for HOLDOFF cycles on every remap.
// - Sits between the peripheral cluster and the top-level tristate pads; pads are not instantiated here.
// PARAMETERS
// - N_PMOD   4    Pmod ports, 1..32.
// - PIN_W    4    Pins per Pmod port and per peripheral channel.
// - N_PERIPH 12   Peripheral channels, 1..127.
// - HOLDOFF  4    Cycles of forced OE=0 on a Pmod after its mapping changes; 0 switches immediately.
// - INITIAL  '0   N_PMOD*8 bits; byte pm is the reset value of MAP[pm].
// PORTS
// - clk          in   1                Single clock for the whole block.
// - rst          in   1                Synchronous, active-high reset.
// - pmod_in      in   N_PMOD*PIN_W     Pad input values.
// - pmod_out     out  N_PMOD*PIN_W     Pad output values.
// - pmod_oe      out  N_PMOD*PIN_W     Pad output enables.
// - periph_out   in   N_PERIPH*PIN_W   Peripheral drive values.
// - periph_oe    in   N_PERIPH*PIN_W   Peripheral output enables.
// - periph_in    out  N_PERIPH*PIN_W   Values returned to the peripherals.
// - ctrl_aw{addr[7:0],prot[2:0],valid,ready}, ctrl_w{data[31:0],strb[3:0],valid,ready}
//   ctrl_b{resp[1:0],valid,ready}, ctrl_ar{addr[7:0],prot[2:0],valid,ready}
//   ctrl_r{data[31:0],resp[1:0],valid,ready}   AXI4-Lite slave; prot is ignored.
// BEHAVIOUR
// Register map (word addresses):
// - 0x00+4*pm  MAP[pm], RW.
//   - bit7 = EN; bits6:0 = SEL (peripheral index).
// - 0x80  STATUS, RO.
//   - bit pm = Pmod pm has lost a conflict or is in holdoff.
// - 0x84  INFO, RO = {8'd0, PIN_W[7:0], N_PERIPH[7:0], N_PMOD[7:0]}.
// - Any other address returns resp=SLVERR (2'b10); reads on such addresses return rdata=0.
// Write channel:
// - awready and wready are asserted together, only when awvalid & wvalid & !bvalid.
// - Registers update on the cycle after the handshake; bvalid rises on that same cycle.
// - bvalid holds until bready. One write is outstanding at a time.
// - wstrb[0]=0 leaves MAP unchanged and the response is OKAY.
// - A write with EN=1 and SEL>=N_PERIPH is rejected: SLVERR, MAP unchanged.
// - Writes to STATUS or INFO return SLVERR.
// Read channel:
// - arready is asserted when !rvalid.
// - rdata and rresp are registered; rvalid rises 1 cycle after the handshake and holds until rready.
// - Read and write channels are independent and may complete in the same cycle.
// Remap sequencing, per Pmod:
// - The block keeps an ACTIVE copy of each MAP and a counter HO[pm].
// - On a MAP write whose value differs from ACTIVE: HO <= HOLDOFF.
//   - While HO!=0, pmod_oe[pm]=0 and pmod_out[pm]=0; HO decrements by 1 per cycle.
//   - When HO==0, ACTIVE <= MAP.
// - Writing a value equal to ACTIVE does not start a holdoff.
// - A write during holdoff reloads HO with HOLDOFF and takes the newest value.
// - HOLDOFF=0: ACTIVE tracks MAP on the cycle after the write.
// Muxing (combinational from ACTIVE):
// - An enabled Pmod p with SEL=s drives pmod_out/oe[p] = periph_out/oe[s], and periph_in[s] = pmod_in[p].
// - A disabled Pmod drives out=0, oe=0.
// - Unmapped peripherals read periph_in = 0.
// - Conflict: several enabled Pmods select the same s.
//   - The lowest-numbered Pmod wins.
//   - Each losing Pmod drives out=0, oe=0 and has its STATUS bit set.
// - Input path latency: 0 cycles (or 2 cycles, see CONFIGURATION). Output path latency: 0 cycles.
// Reset values:
// - MAP = ACTIVE = INITIAL; HO = 0.
// - All ready and valid outputs = 0; bresp = rresp = 0; rdata = 0.
// - pmod_out and pmod_oe follow ACTIVE from the first cycle after reset.
// - Reset asserted mid-transaction drops all pending responses.
// CONFIGURATION
// - PMOD_XBAR_SYNC_EN defined:
//   - pmod_in passes through a two-flop synchroniser (reset value 0) before the mux.
//   - Input latency becomes 2 cycles.
// - PMOD_XBAR_SYNC_EN undefined:
//   - pmod_in is used directly; input latency is 0.
// TESTING
// 1. Reset with INITIAL=0 -> all pmod_oe=0; read 0x84 -> 0x0004_0C04; read 0x80 -> 0.
// 2. Write 0x04 <= 0x85, periph_oe[5]=4'hF, periph_out[5]=4'hA, HOLDOFF=4
//    -> pmod_oe[1]=0 for 4 cycles after bvalid, then pmod_out[1]=4'hA, oe=4'hF.
// 3. MAP[0]=MAP[2]=0x83 -> Pmod0 drives channel 3; Pmod2 oe=0; STATUS=0x4.
//    Clear MAP[0] -> Pmod2 takes over after holdoff; STATUS=0.
// 4. Write 0x08 <= 0x8C (SEL=12) -> bresp=SLVERR, MAP[2] unchanged.
//    Read 0x90 -> rresp=SLVERR, rdata=0.
// 5. Write MAP[1] twice, 2 cycles apart -> one holdoff, restarted from the second write, ending with the second value.
//    bready held low 5 cycles -> bvalid stable, awready=0 throughout.
// 6. pmod_in[3:0]=4'h5 with Pmod0 on channel 7 -> periph_in[7] = 4'h5 same cycle (2 cycles later with PMOD_XBAR_SYNC_EN).

Source files
------------

// File: rtl/pmod_xbar_axil_if.sv
// AXI4-Lite control port of the Pmod crossbar: 8-bit byte address, 32-bit data.
// Every channel moves a beat on the cycle where valid and ready are both high.
interface pmod_xbar_axil_if;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

// File: rtl/pmod_xbar_axil.sv
// Pmod-to-peripheral crossbar with AXI4-Lite map registers and per-Pmod remap holdoff.
// Optional PMOD_XBAR_SYNC_EN adds a two-flop synchroniser on pmod_in.
module pmod_xbar_axil #(
  parameter int                  N_PMOD   = 4,
  parameter int                  PIN_W    = 4,
  parameter int                  N_PERIPH = 12,
  parameter int                  HOLDOFF  = 4,
  parameter logic [N_PMOD*8-1:0] INITIAL  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PMOD*PIN_W-1:0]   pmod_in,
  output logic [N_PMOD*PIN_W-1:0]   pmod_out,
  output logic [N_PMOD*PIN_W-1:0]   pmod_oe,
  input  logic [N_PERIPH*PIN_W-1:0] periph_out,
  input  logic [N_PERIPH*PIN_W-1:0] periph_oe,
  output logic [N_PERIPH*PIN_W-1:0] periph_in,
  pmod_xbar_axil_if.slave           ctrl
);
  localparam int          HO_W        = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] INFO        = {8'd0, 8'(PIN_W), 8'(N_PERIPH), 8'(N_PMOD)};

  logic [7:0]      map_q [N_PMOD];
  logic [7:0]      map_d [N_PMOD];
  logic [7:0]      active_q [N_PMOD];
  logic [7:0]      active_d [N_PMOD];
  logic [HO_W-1:0] ho_q [N_PMOD];
  logic [HO_W-1:0] ho_d [N_PMOD];
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [N_PMOD*PIN_W-1:0] pin_s;

`ifdef PMOD_XBAR_SYNC_EN
  logic [N_PMOD*PIN_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  assign sync1_d = pmod_in;
  assign sync2_d = sync1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign pin_s = sync2_q;
`else
  assign pin_s = pmod_in;
`endif

  // AW and W are accepted together, and only while no write response is pending.
  logic w_hs, r_hs;
  assign w_hs         = ctrl.awvalid & ctrl.wvalid & ~bvalid_q & ~rst;
  assign ctrl.awready = w_hs;
  assign ctrl.wready  = w_hs;
  assign ctrl.arready = ~rvalid_q & ~rst;
  assign r_hs         = ctrl.arvalid & ctrl.arready;
  assign ctrl.bvalid  = bvalid_q;
  assign ctrl.bresp   = bresp_q;
  assign ctrl.rvalid  = rvalid_q;
  assign ctrl.rresp   = rresp_q;
  assign ctrl.rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{ctrl.awprot, ctrl.arprot, ctrl.wdata[31:8], ctrl.wstrb[3:1]};

  logic [4:0] wr_idx, rd_idx;
  logic       wr_is_map, wr_bad_sel, wr_commit;
  assign wr_idx     = ctrl.awaddr[6:2];
  assign rd_idx     = ctrl.araddr[6:2];
  assign wr_is_map  = ~ctrl.awaddr[7] & (ctrl.awaddr[1:0] == 2'b00) & (int'(wr_idx) < N_PMOD);
  assign wr_bad_sel = ctrl.wdata[7] & (int'(ctrl.wdata[6:0]) >= N_PERIPH);
  assign wr_commit  = w_hs & wr_is_map & ctrl.wstrb[0] & ~wr_bad_sel;

  // Lowest-numbered enabled Pmod owns a channel; holdoff only blanks the pad drivers.
  logic [N_PMOD-1:0] sel_ok, win, status;
  always_comb begin
    sel_ok    = '0;
    win       = '0;
    status    = '0;
    pmod_out  = '0;
    pmod_oe   = '0;
    periph_in = '0;
    for (int p = 0; p < N_PMOD; p++)
      sel_ok[p] = active_q[p][7] & (int'(active_q[p][6:0]) < N_PERIPH);
    for (int p = 0; p < N_PMOD; p++) begin
      win[p] = sel_ok[p];
      for (int q = 0; q < N_PMOD; q++)
        if (q < p && sel_ok[q] && active_q[q][6:0] == active_q[p][6:0]) win[p] = 1'b0;
      status[p] = (sel_ok[p] & ~win[p]) | (ho_q[p] != '0);
      if (win[p]) begin
        periph_in[int'(active_q[p][6:0])*PIN_W +: PIN_W] = pin_s[p*PIN_W +: PIN_W];
        if (ho_q[p] == '0) begin
          pmod_out[p*PIN_W +: PIN_W] = periph_out[int'(active_q[p][6:0])*PIN_W +: PIN_W];
          pmod_oe[p*PIN_W +: PIN_W]  = periph_oe[int'(active_q[p][6:0])*PIN_W +: PIN_W];
        end
      end
    end
  end

  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (!ctrl.araddr[7] && ctrl.araddr[1:0] == 2'b00 && int'(rd_idx) < N_PMOD) begin
      rd_resp = RESP_OKAY;
      for (int pm = 0; pm < N_PMOD; pm++)
        if (int'(rd_idx) == pm) rd_data = {24'd0, map_q[pm]};
    end else if (ctrl.araddr == 8'h80) begin
      rd_resp = RESP_OKAY;
      rd_data = 32'(status);
    end else if (ctrl.araddr == 8'h84) begin
      rd_resp = RESP_OKAY;
      rd_data = INFO;
    end
  end

  // A new write that differs from ACTIVE reloads the holdoff; ACTIVE follows MAP once it expires.
  always_comb begin
    map_d    = map_q;
    active_d = active_q;
    ho_d     = ho_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (bvalid_q && ctrl.bready) bvalid_d = 1'b0;
    if (w_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = (!wr_is_map || (ctrl.wstrb[0] && wr_bad_sel)) ? RESP_SLVERR : RESP_OKAY;
    end
    if (rvalid_q && ctrl.rready) rvalid_d = 1'b0;
    if (r_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_resp;
      rdata_d  = rd_data;
    end
    for (int pm = 0; pm < N_PMOD; pm++) begin
      if (ho_q[pm] != '0) ho_d[pm] = ho_q[pm] - HO_W'(1);
      if (wr_commit && int'(wr_idx) == pm) begin
        map_d[pm] = ctrl.wdata[7:0];
        if (ctrl.wdata[7:0] != active_q[pm]) ho_d[pm] = HO_W'(HOLDOFF);
      end
      if (ho_d[pm] == '0) active_d[pm] = map_d[pm];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int pm = 0; pm < N_PMOD; pm++) begin
        map_q[pm]    <= INITIAL[pm*8 +: 8];
        active_q[pm] <= INITIAL[pm*8 +: 8];
        ho_q[pm]     <= '0;
      end
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      map_q    <= map_d;
      active_q <= active_d;
      ho_q     <= ho_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_pmod_xbar_axil.sv
// Self-checking bench for pmod_xbar_axil: directed scenarios plus randomized AXI traffic
// compared against a per-Pmod behavioural model of mapping, ownership and holdoff.
`timescale 1ns/1ps
module tb_pmod_xbar_axil;
  localparam int N_PMOD   = 4;
  localparam int PIN_W    = 4;
  localparam int N_PERIPH = 12;
  localparam int HOLDOFF  = 4;
  localparam int PW       = N_PMOD * PIN_W;
  localparam int CW       = N_PERIPH * PIN_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pmod_in = '0;
  logic [PW-1:0] pmod_out, pmod_oe;
  logic [CW-1:0] periph_out = '0;
  logic [CW-1:0] periph_oe = '0;
  logic [CW-1:0] periph_in;

  pmod_xbar_axil_if bus ();

  pmod_xbar_axil #(
    .N_PMOD(N_PMOD), .PIN_W(PIN_W), .N_PERIPH(N_PERIPH), .HOLDOFF(HOLDOFF), .INITIAL('0)
  ) dut (
    .clk(clk), .rst(rst), .pmod_in(pmod_in), .pmod_out(pmod_out), .pmod_oe(pmod_oe),
    .periph_out(periph_out), .periph_oe(periph_oe), .periph_in(periph_in), .ctrl(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard and model state
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  m_map [N_PMOD];
  logic [7:0]  m_active [N_PMOD];
  int          m_ho [N_PMOD];
  logic        m_bvalid, m_rvalid;
  logic [PW-1:0] m_sync1, m_sync2;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic        last_w_hs, last_r_hs, last_b_done, last_r_done;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic en_ok(input int p);
    return m_active[p][7] && (int'(m_active[p][6:0]) < N_PERIPH);
  endfunction

  function automatic int owner_of(input int s);
    for (int p = 0; p < N_PMOD; p++)
      if (en_ok(p) && int'(m_active[p][6:0]) == s) return p;
    return -1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] st;
    st = '0;
    for (int p = 0; p < N_PMOD; p++)
      st[p] = (m_ho[p] != 0) || (en_ok(p) && owner_of(int'(m_active[p][6:0])) != p);
    return st;
  endfunction

  function automatic logic [33:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a[6:2]);
    if (!a[7] && a[1:0] == 2'b00 && idx < N_PMOD) return {2'b00, 24'd0, m_map[idx]};
    if (a == 8'h80) return {2'b00, m_status()};
    if (a == 8'h84) return {2'b00, 32'h0004_0C04};
    return {2'b10, 32'd0};
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                              input logic [3:0] st);
    int idx;
    idx = int'(a[6:2]);
    if (a[7] || a[1:0] != 2'b00 || idx >= N_PMOD) return 2'b10;
    if (!st[0]) return 2'b00;
    if (d[7] && int'(d[6:0]) >= N_PERIPH) return 2'b10;
    m_map[idx] = d[7:0];
    if (d[7:0] != m_active[idx]) m_ho[idx] = HOLDOFF;
    return 2'b00;
  endfunction

  task automatic check_cycle();
    logic [63:0]   e_out, e_oe, e_pin;
    logic [PW-1:0] pin;
    int            s, o;
`ifdef PMOD_XBAR_SYNC_EN
    pin = m_sync2;
`else
    pin = pmod_in;
`endif
    e_out = '0;
    e_oe  = '0;
    e_pin = '0;
    for (int p = 0; p < N_PMOD; p++) begin
      s = int'(m_active[p][6:0]);
      if (en_ok(p) && owner_of(s) == p && m_ho[p] == 0) begin
        e_out[p*PIN_W +: PIN_W] = periph_out[s*PIN_W +: PIN_W];
        e_oe[p*PIN_W +: PIN_W]  = periph_oe[s*PIN_W +: PIN_W];
      end
    end
    for (int c = 0; c < N_PERIPH; c++) begin
      o = owner_of(c);
      if (o >= 0) e_pin[c*PIN_W +: PIN_W] = pin[o*PIN_W +: PIN_W];
    end
    check_eq("pmod_out", 64'(pmod_out), e_out);
    check_eq("pmod_oe", 64'(pmod_oe), e_oe);
    check_eq("periph_in", 64'(periph_in), e_pin);
    check_eq("awready", 64'(bus.awready), 64'(bus.awvalid && bus.wvalid && !m_bvalid));
    check_eq("wready", 64'(bus.wready), 64'(bus.awvalid && bus.wvalid && !m_bvalid));
    check_eq("arready", 64'(bus.arready), 64'(!m_rvalid));
    check_eq("bvalid", 64'(bus.bvalid), 64'(m_bvalid));
    check_eq("rvalid", 64'(bus.rvalid), 64'(m_rvalid));
  endtask

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic step();
    logic w_hs, r_hs, b_done, r_done;
    logic [1:0]  eb;
    logic [33:0] er;
    @(negedge clk);
    check_cycle();
    w_hs   = bus.awvalid && bus.wvalid && !m_bvalid;
    r_hs   = bus.arvalid && !m_rvalid;
    b_done = m_bvalid && bus.bready;
    r_done = m_rvalid && bus.rready;
    if (b_done) begin
      if (exp_b_q.size() > 0) begin
        eb = exp_b_q.pop_front();
        check_eq("bresp", 64'(bus.bresp), 64'(eb));
      end
      last_bresp = bus.bresp;
      m_bvalid   = 1'b0;
    end
    if (r_done) begin
      if (exp_r_q.size() > 0) begin
        er = exp_r_q.pop_front();
        check_eq("rdata", 64'(bus.rdata), 64'(er[31:0]));
        check_eq("rresp", 64'(bus.rresp), 64'(er[33:32]));
      end
      last_rdata = bus.rdata;
      last_rresp = bus.rresp;
      m_rvalid   = 1'b0;
    end
    if (r_hs) begin
      exp_r_q.push_back(model_read(bus.araddr));
      m_rvalid = 1'b1;
    end
    for (int p = 0; p < N_PMOD; p++) if (m_ho[p] > 0) m_ho[p]--;
    if (w_hs) begin
      exp_b_q.push_back(model_write(bus.awaddr, bus.wdata, bus.wstrb));
      m_bvalid = 1'b1;
    end
    for (int p = 0; p < N_PMOD; p++) if (m_ho[p] == 0) m_active[p] = m_map[p];
    m_sync2     = m_sync1;
    m_sync1     = pmod_in;
    last_w_hs   = w_hs;
    last_r_hs   = r_hs;
    last_b_done = b_done;
    last_r_done = r_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    bus.bready  = 1'b1;
    bus.rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < N_PMOD; p++) begin
      m_map[p]    = '0;
      m_active[p] = '0;
      m_ho[p]     = 0;
    end
    m_bvalid = 1'b0;
    m_rvalid = 1'b0;
    m_sync1  = '0;
    m_sync2  = '0;
    exp_b_q.delete();
    exp_r_q.delete();
    check_eq("rst_oe", 64'(pmod_oe), 64'd0);
    check_eq("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("rst_rdata", 64'(bus.rdata), 64'd0);
    check_eq("rst_arready", 64'(bus.arready), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_w_hs();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = last_w_hs;
    end
    if (!seen) check_eq("w_hs_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_b();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = last_b_done;
    end
    if (!seen) check_eq("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_r(input logic want_hs);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = want_hs ? last_r_hs : last_r_done;
    end
    if (!seen) check_eq("r_timeout", 64'd0, 64'd1);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bhold);
    bus.awaddr  = addr;
    bus.awprot  = 3'($urandom_range(0, 7));
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = (bhold == 0);
    wait_w_hs();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    repeat (bhold) step();
    bus.bready = 1'b1;
    wait_b();
  endtask

  task automatic axi_read(input logic [7:0] addr, input int rhold);
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom_range(0, 7));
    bus.arvalid = 1'b1;
    bus.rready  = (rhold == 0);
    wait_r(1'b1);
    bus.arvalid = 1'b0;
    repeat (rhold) step();
    bus.rready = 1'b1;
    wait_r(1'b0);
  endtask

  task automatic rand_inputs();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    periph_out = t[CW-1:0];
    t = {$urandom(), $urandom()};
    periph_oe = t[CW-1:0];
    t = {$urandom(), $urandom()};
    pmod_in = t[PW-1:0];
  endtask

  initial begin
    logic [7:0] a;
    logic [31:0] d;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    do_reset();

    // Reset state and read-only registers
    step();
    axi_read(8'h84, 0);
    check_eq("info", 64'(last_rdata), 64'h0004_0C04);
    axi_read(8'h80, 1);
    check_eq("status_reset", 64'(last_rdata), 64'd0);

    // Remap Pmod1 onto channel 5: blanked during holdoff, then drives
    periph_oe[5*PIN_W +: PIN_W]  = 4'hF;
    periph_out[5*PIN_W +: PIN_W] = 4'hA;
    axi_write(8'h04, 32'h85, 4'hF, 0);
    check_eq("holdoff_blank", 64'(pmod_oe[7:4]), 64'd0);
    repeat (4) step();
    check_eq("remap_out", 64'(pmod_out[7:4]), 64'hA);
    check_eq("remap_oe", 64'(pmod_oe[7:4]), 64'hF);

    // Conflict on channel 3: Pmod0 wins, Pmod2 loses and flags STATUS
    periph_oe[3*PIN_W +: PIN_W] = 4'hF;
    axi_write(8'h00, 32'h83, 4'hF, 0);
    axi_write(8'h08, 32'h83, 4'hF, 2);
    repeat (6) step();
    check_eq("conflict_loser_oe", 64'(pmod_oe[11:8]), 64'd0);
    axi_read(8'h80, 0);
    check_eq("conflict_status", 64'(last_rdata), 64'h4);
    axi_write(8'h00, 32'h00, 4'hF, 0);
    repeat (6) step();
    check_eq("takeover_oe", 64'(pmod_oe[11:8]), 64'hF);
    axi_read(8'h80, 0);
    check_eq("takeover_status", 64'(last_rdata), 64'd0);

    // Rejected writes and bad addresses
    axi_write(8'h08, 32'h8C, 4'hF, 0);
    check_eq("bad_sel_bresp", 64'(last_bresp), 64'h2);
    axi_read(8'h08, 0);
    check_eq("bad_sel_unchanged", 64'(last_rdata), 64'h83);
    axi_read(8'h90, 0);
    check_eq("bad_addr_rresp", 64'(last_rresp), 64'h2);
    check_eq("bad_addr_rdata", 64'(last_rdata), 64'd0);
    axi_write(8'h80, 32'h1, 4'hF, 0);
    check_eq("ro_write_bresp", 64'(last_bresp), 64'h2);
    axi_write(8'h08, 32'h81, 4'hE, 0);
    check_eq("strb_off_bresp", 64'(last_bresp), 64'h0);

    // Back-to-back remaps of Pmod1, second response held off by bready
    axi_write(8'h04, 32'h81, 4'hF, 0);
    bus.awaddr = 8'h04; bus.wdata = 32'h82; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    wait_w_hs();
    bus.awaddr = 8'h84;
    repeat (5) step();
    check_eq("bhold_awready", 64'(bus.awready), 64'd0);
    check_eq("bhold_bvalid", 64'(bus.bvalid), 64'd1);
    bus.bready = 1'b1;
    wait_w_hs();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_b();
    repeat (6) step();
    axi_read(8'h04, 0);
    check_eq("restart_final_map", 64'(last_rdata), 64'h82);

    // Input path: Pmod0 on channel 7
    axi_write(8'h00, 32'h87, 4'hF, 0);
    repeat (6) step();
    pmod_in[3:0] = 4'h5;
`ifdef PMOD_XBAR_SYNC_EN
    repeat (2) step();
`else
    #1;
`endif
    check_eq("input_path", 64'(periph_in[7*PIN_W +: PIN_W]), 64'h5);
    step();

    // Reset while a write response is pending
    bus.awaddr = 8'h0C; bus.wdata = 32'h81; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    wait_w_hs();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    step();
    do_reset();
    step();
    check_eq("mid_reset_bvalid", 64'(bus.bvalid), 64'd0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      rand_inputs();
      case ($urandom_range(0, 5))
        0, 1: begin
          a = 8'($urandom_range(0, N_PMOD - 1) * 4);
          d = {($urandom_range(0, 3) == 0) ? 24'($urandom()) : 24'd0,
               1'($urandom_range(0, 1)), 7'($urandom_range(0, N_PERIPH + 1))};
          axi_write(a, d, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                    $urandom_range(0, 3));
        end
        2: axi_write(8'($urandom_range(0, 255)), $urandom(), 4'hF, $urandom_range(0, 2));
        3, 4: begin
          case ($urandom_range(0, 3))
            0:       a = 8'h80;
            1:       a = 8'h84;
            2:       a = 8'($urandom_range(0, 255));
            default: a = 8'($urandom_range(0, N_PMOD - 1) * 4);
          endcase
          axi_read(a, $urandom_range(0, 3));
        end
        default: repeat ($urandom_range(1, 5)) step();
      endcase
    end
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
